// File: rtl/rpn_pkg.sv
// Shared types for the RPN token sequencer: opcodes, FSM states and the
// depth-counter width helper.
package rpn_pkg;

  typedef enum logic [2:0] {
    OP_PUSH = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_XOR  = 3'b100,
    OP_DROP = 3'b101
  } rpn_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PUSH   = 3'd1,
    ST_POP_B  = 3'd2,
    ST_POP_A  = 3'd3,
    ST_PUSH_R = 3'd4
  } rpn_state_e;

  // Counter must hold 0..DEPTH inclusive.
  function automatic int unsigned depth_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned RPN_DEPTH_DEFAULT   = 8;
  localparam int unsigned RPN_DEPTH_W_DEFAULT = depth_w(RPN_DEPTH_DEFAULT);

  function automatic logic is_binary(input rpn_op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational binary ALU; a is the deeper operand, results wrap modulo 2^WIDTH.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  rpn_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rpn_sequencer.sv
// Reverse-Polish token sequencer driving an external LIFO through push/pull
// strobes, tracking depth itself and pushing ALU results back onto the stack.
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int DW   = depth_w(DEPTH)
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic [2:0]       tok_op,
  input  logic [WIDTH-1:0] tok_data,
  output logic             stk_psh,
  output logic             stk_pll,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  output logic [DW-1:0]    depth,
  output logic             res_valid,
  output logic [WIDTH-1:0] res,
  output logic             err_ovf,
  output logic             err_unf,
  output logic             err_op
);

  localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);
  localparam logic [DW-1:0] DEPTH_ONE  = DW'(1);

  rpn_state_e       state_q, state_d;
  logic [DW-1:0]    depth_q, depth_d;
  rpn_op_e          op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             eop_q, eop_d;

  rpn_op_e          tok_op_e;
  logic [WIDTH-1:0] alu_y;

  assign tok_op_e = rpn_op_e'(tok_op);

  rpn_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y)
  );

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    eop_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tok_valid) begin
          // Error tokens are consumed here without touching the stack.
          case (tok_op_e)
            OP_PUSH: begin
              if (depth_q == DEPTH_FULL) begin
                ovf_d = 1'b1;
              end else begin
                opnd_d  = tok_data;
                state_d = ST_PUSH;
              end
            end
            OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
              if ((depth_q == '0) || (depth_q == DEPTH_ONE)) begin
                unf_d = 1'b1;
              end else begin
                op_d    = tok_op_e;
                state_d = ST_POP_B;
              end
            end
            OP_DROP: begin
              if (depth_q == '0) begin
                unf_d = 1'b1;
              end else begin
                op_d    = OP_DROP;
                state_d = ST_POP_B;
              end
            end
            default: eop_d = 1'b1;
          endcase
        end
      end
      ST_PUSH: begin
        depth_d = depth_q + DEPTH_ONE;
        state_d = ST_IDLE;
      end
      ST_POP_B: begin
        b_d     = stk_dout;
        depth_d = depth_q - DEPTH_ONE;
        state_d = is_binary(op_q) ? ST_POP_A : ST_IDLE;
      end
      ST_POP_A: begin
        a_d     = stk_dout;
        depth_d = depth_q - DEPTH_ONE;
        state_d = ST_PUSH_R;
      end
      ST_PUSH_R: begin
        res_d   = alu_y;
        depth_d = depth_q + DEPTH_ONE;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      depth_q <= '0;
      op_q    <= OP_PUSH;
      opnd_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      eop_q   <= eop_d;
    end
  end

  // Strobes decode from state alone; the result is shown live during PUSH_R.
  always_comb begin
    tok_ready = (state_q == ST_IDLE);
    stk_psh   = (state_q == ST_PUSH) || (state_q == ST_PUSH_R);
    stk_pll   = (state_q == ST_POP_B) || (state_q == ST_POP_A);
    res_valid = (state_q == ST_PUSH_R);
    stk_din   = (state_q == ST_PUSH_R) ? alu_y : opnd_q;
    res       = (state_q == ST_PUSH_R) ? alu_y : res_q;
  end

  assign depth   = depth_q;
  assign err_ovf = ovf_q;
  assign err_unf = unf_q;
  assign err_op  = eop_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Bench for rpn_sequencer: behavioural LIFO, queue-based reference model,
// directed table, hand-written stall/reset sequences and random tokens.
module tb_rpn_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH + 1);

  logic             clkin = 1'b0;
  logic             rst;
  logic             tok_valid;
  logic             tok_ready;
  logic [2:0]       tok_op;
  logic [WIDTH-1:0] tok_data;
  logic             stk_psh;
  logic             stk_pll;
  logic [WIDTH-1:0] stk_din;
  logic [WIDTH-1:0] stk_dout;
  logic [DW-1:0]    depth;
  logic             res_valid;
  logic [WIDTH-1:0] res;
  logic             err_ovf;
  logic             err_unf;
  logic             err_op;

  always #5 clkin = ~clkin;

  rpn_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clkin     (clkin),
    .rst       (rst),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_op    (tok_op),
    .tok_data  (tok_data),
    .stk_psh   (stk_psh),
    .stk_pll   (stk_pll),
    .stk_din   (stk_din),
    .stk_dout  (stk_dout),
    .depth     (depth),
    .res_valid (res_valid),
    .res       (res),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf),
    .err_op    (err_op)
  );

  // Behavioural LIFO: top word shown combinationally.
  logic [WIDTH-1:0] lifo_mem [DEPTH];
  int               lifo_sp;

  always @(posedge clkin or posedge rst) begin
    if (rst) begin
      lifo_sp <= 0;
    end else if (stk_psh && lifo_sp < DEPTH) begin
      lifo_mem[lifo_sp] <= stk_din;
      lifo_sp <= lifo_sp + 1;
    end else if (stk_pll && lifo_sp > 0) begin
      lifo_sp <= lifo_sp - 1;
    end
  end

  always_comb begin
    stk_dout = '0;
    if (lifo_sp > 0) stk_dout = lifo_mem[lifo_sp-1];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] lifo_top();
    if (lifo_sp > 0) return lifo_mem[lifo_sp-1];
    return '0;
  endfunction

  // Reference model state
  logic [WIDTH-1:0] mstk[$];
  logic [WIDTH-1:0] mres;

  function automatic logic [WIDTH-1:0] alu_ref(input logic [2:0] op, input int a, input int b);
    int r;
    case (op)
      3'd1: r = a + b;
      3'd2: r = a - b;
      3'd3: r = a & b;
      3'd4: r = a ^ b;
      default: r = 0;
    endcase
    return WIDTH'(r % 256 < 0 ? r % 256 + 256 : r % 256);
  endfunction

  // Observations from the last token
  int               obs_busy, obs_psh, obs_pll, obs_rv;
  logic [2:0]       obs_err;
  logic [WIDTH-1:0] obs_res_rv, obs_pop, obs_res_end;

  task automatic do_reset();
    rst = 1'b1;
    tok_valid = 1'b0;
    tok_op = '0;
    tok_data = '0;
    @(posedge clkin);
    @(negedge clkin);
    rst = 1'b0;
    mstk.delete();
    mres = '0;
  endtask

  task automatic apply_token(input logic [2:0] op, input logic [WIDTH-1:0] data);
    int guard;
    @(negedge clkin);
    tok_valid = 1'b1;
    tok_op = op;
    tok_data = data;
    guard = 0;
    while (!tok_ready && guard < 20) begin
      @(negedge clkin);
      guard++;
    end
    if (!tok_ready) chk("ready_wait_timeout", 0, 1);
    @(posedge clkin);
    obs_busy = 0; obs_psh = 0; obs_pll = 0; obs_rv = 0;
    obs_err = '0; obs_res_rv = '0; obs_pop = '0;
    guard = 0;
    forever begin
      @(negedge clkin);
      tok_valid = 1'b0;
      obs_err |= {err_ovf, err_unf, err_op};
      if (stk_psh && stk_pll) chk("psh_pll_both_high", 1, 0);
      if (stk_psh) obs_psh++;
      if (stk_pll) begin
        if (obs_pll == 0) obs_pop = stk_dout;
        obs_pll++;
      end
      if (res_valid) begin
        obs_rv++;
        obs_res_rv = res;
      end
      if (tok_ready) break;
      obs_busy++;
      guard++;
      if (guard > 10) begin
        chk("busy_timeout", 0, 1);
        break;
      end
    end
    obs_res_end = res;
  endtask

  task automatic model_step(input logic [2:0] op, input logic [WIDTH-1:0] data);
    int e_busy = 0, e_psh = 0, e_pll = 0, e_rv = 0, n;
    logic [2:0] e_err = '0;
    logic [WIDTH-1:0] a, b, e_pop = '0, r = '0;
    n = mstk.size();
    case (op)
      3'd0: if (n == DEPTH) e_err = 3'b100;
            else begin mstk.push_back(data); e_busy = 1; e_psh = 1; end
      3'd1, 3'd2, 3'd3, 3'd4:
        if (n < 2) e_err = 3'b010;
        else begin
          b = mstk.pop_back(); a = mstk.pop_back();
          r = alu_ref(op, int'(a), int'(b));
          mstk.push_back(r); mres = r; e_pop = b;
          e_busy = 3; e_pll = 2; e_psh = 1; e_rv = 1;
        end
      3'd5: if (n == 0) e_err = 3'b010;
            else begin e_pop = mstk.pop_back(); e_busy = 1; e_pll = 1; end
      default: e_err = 3'b001;
    endcase
    chk("m_busy", obs_busy, e_busy);
    chk("m_err", obs_err, e_err);
    chk("m_psh", obs_psh, e_psh);
    chk("m_pll", obs_pll, e_pll);
    chk("m_res_valid", obs_rv, e_rv);
    if (e_rv > 0) chk("m_res_at_valid", obs_res_rv, r);
    if (e_pll > 0) chk("m_first_pop", obs_pop, e_pop);
    chk("m_res_hold", obs_res_end, mres);
    chk("m_depth", depth, mstk.size());
    chk("m_lifo_sp", lifo_sp, mstk.size());
    if (mstk.size() > 0) chk("m_lifo_top", lifo_top(), mstk[$]);
  endtask

  task automatic run_tok(input logic [2:0] op, input logic [WIDTH-1:0] data);
    apply_token(op, data);
    model_step(op, data);
  endtask

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] data;
    logic [2:0]       err;
    logic [WIDTH-1:0] res;
    int               dep;
    logic             chk_pop;
    logic [WIDTH-1:0] pop;
  } vec_t;

  vec_t vt[$];

  task automatic addv(input logic [2:0] op, input logic [WIDTH-1:0] data, input logic [2:0] err,
                      input logic [WIDTH-1:0] r, input int dep, input logic cp, input logic [WIDTH-1:0] pop);
    vec_t v;
    v.op = op; v.data = data; v.err = err; v.res = r; v.dep = dep; v.chk_pop = cp; v.pop = pop;
    vt.push_back(v);
  endtask

  initial begin
    // Directed table: {op, data, err{ovf,unf,op}, res, depth, check_pop, pop}
    addv(3'd0, 8'h05, 3'b000, 8'h00, 1, 0, 8'h00);
    addv(3'd0, 8'h03, 3'b000, 8'h00, 2, 0, 8'h00);
    addv(3'd2, 8'h00, 3'b000, 8'h02, 1, 1, 8'h03);
    addv(3'd5, 8'h00, 3'b000, 8'h02, 0, 1, 8'h02);
    addv(3'd0, 8'h03, 3'b000, 8'h02, 1, 0, 8'h00);
    addv(3'd0, 8'h05, 3'b000, 8'h02, 2, 0, 8'h00);
    addv(3'd2, 8'h00, 3'b000, 8'hFE, 1, 1, 8'h05);
    addv(3'd5, 8'h00, 3'b000, 8'hFE, 0, 1, 8'hFE);
    addv(3'd0, 8'hFF, 3'b000, 8'hFE, 1, 0, 8'h00);
    addv(3'd0, 8'h02, 3'b000, 8'hFE, 2, 0, 8'h00);
    addv(3'd1, 8'h00, 3'b000, 8'h01, 1, 1, 8'h02);
    addv(3'd5, 8'h00, 3'b000, 8'h01, 0, 1, 8'h01);
    addv(3'd0, 8'h07, 3'b000, 8'h01, 1, 0, 8'h00);
    addv(3'd1, 8'h00, 3'b010, 8'h01, 1, 0, 8'h00);
    addv(3'd5, 8'h00, 3'b000, 8'h01, 0, 1, 8'h07);
    addv(3'd5, 8'h00, 3'b010, 8'h01, 0, 0, 8'h00);
    addv(3'd7, 8'h00, 3'b001, 8'h01, 0, 0, 8'h00);
    addv(3'd6, 8'h00, 3'b001, 8'h01, 0, 0, 8'h00);
    addv(3'd0, 8'hAA, 3'b000, 8'h01, 1, 0, 8'h00);
    addv(3'd0, 8'h0F, 3'b000, 8'h01, 2, 0, 8'h00);
    addv(3'd3, 8'h00, 3'b000, 8'h0A, 1, 1, 8'h0F);
    addv(3'd0, 8'hF0, 3'b000, 8'h0A, 2, 0, 8'h00);
    addv(3'd4, 8'h00, 3'b000, 8'hFA, 1, 1, 8'hF0);
    addv(3'd5, 8'h00, 3'b000, 8'hFA, 0, 1, 8'hFA);

    // Reset state
    rst = 1'b1;
    tok_valid = 1'b0; tok_op = '0; tok_data = '0;
    mres = '0;
    #1;
    chk("rst_tok_ready", tok_ready, 1);
    chk("rst_strobes", {stk_psh, stk_pll}, 2'b00);
    chk("rst_stk_din", stk_din, 0);
    chk("rst_depth", depth, 0);
    chk("rst_res", {res_valid, res}, 0);
    chk("rst_errs", {err_ovf, err_unf, err_op}, 3'b000);
    do_reset();

    foreach (vt[i]) begin
      run_tok(vt[i].op, vt[i].data);
      chk($sformatf("tbl%0d_err", i), obs_err, vt[i].err);
      chk($sformatf("tbl%0d_res", i), obs_res_end, vt[i].res);
      chk($sformatf("tbl%0d_depth", i), depth, vt[i].dep);
      if (vt[i].chk_pop) chk($sformatf("tbl%0d_pop", i), obs_pop, vt[i].pop);
    end

    // Overflow, then a binary op at full depth
    do_reset();
    for (int i = 0; i < DEPTH; i++) run_tok(3'd0, WIDTH'(8'h10 + i));
    run_tok(3'd0, 8'h99);
    chk("ovf_flag", obs_err, 3'b100);
    chk("ovf_depth", depth, DEPTH);
    chk("ovf_top", lifo_top(), 8'h17);
    run_tok(3'd2, 8'h00);
    chk("full_sub_res", obs_res_end, 8'hFF);
    chk("full_sub_depth", depth, DEPTH - 1);
    for (int i = 0; i < DEPTH - 1; i++) run_tok(3'd5, 8'h00);
    chk("drained_depth", depth, 0);

    // Token held during the busy states is accepted only back in IDLE
    do_reset();
    run_tok(3'd0, 8'h01);
    run_tok(3'd0, 8'h02);
    @(negedge clkin);
    tok_valid = 1'b1; tok_op = 3'd1; tok_data = 8'h00;
    @(posedge clkin);
    @(negedge clkin);
    tok_op = 3'd0; tok_data = 8'h09;
    chk("stall_popb_ready", tok_ready, 0);
    @(negedge clkin);
    chk("stall_popa_ready", {tok_ready, stk_pll}, 2'b01);
    @(negedge clkin);
    chk("stall_pushr", {tok_ready, res_valid, res}, {2'b01, 8'h03});
    @(negedge clkin);
    chk("stall_idle", {tok_ready, 4'(depth)}, {1'b1, 4'd1});
    @(negedge clkin);
    tok_valid = 1'b0;
    chk("stall_push_busy", tok_ready, 0);
    @(negedge clkin);
    chk("stall_after_depth", depth, 2);
    chk("stall_after_top", lifo_top(), 8'h09);
    mstk.delete(); mstk.push_back(8'h03); mstk.push_back(8'h09); mres = 8'h03;
    run_tok(3'd1, 8'h00);
    chk("stall_sum", obs_res_end, 8'h0C);

    // Reset asserted during POP_A abandons the token
    do_reset();
    run_tok(3'd0, 8'h0A);
    run_tok(3'd0, 8'h0B);
    @(negedge clkin);
    tok_valid = 1'b1; tok_op = 3'd2; tok_data = 8'h00;
    @(posedge clkin);
    @(negedge clkin);
    tok_valid = 1'b0;
    @(negedge clkin);
    chk("midrst_in_popa", stk_pll, 1);
    rst = 1'b1;
    #1;
    chk("midrst_idle", tok_ready, 1);
    chk("midrst_depth", depth, 0);
    chk("midrst_strobes", {stk_psh, stk_pll, res_valid}, 3'b000);
    @(negedge clkin);
    rst = 1'b0;
    mstk.delete(); mres = '0;
    run_tok(3'd0, 8'h04);
    chk("midrst_push_depth", depth, 1);
    run_tok(3'd5, 8'h00);
    chk("midrst_pop_val", obs_pop, 8'h04);

    // Random tokens against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [2:0] op;
      r = $urandom_range(0, 15);
      op = (r < 6) ? 3'd0 : 3'($urandom_range(1, 7));
      run_tok(op, WIDTH'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
